rms_sqrt_scheduler: RTL

//  Shares one multi-cycle integer square-root engine between NCH requesters
//  (per-phase V/I mean-square accumulators) in the RMS path of the enhancer.

---
 rtl/rms_sqrt_pkg.sv | 32 +++
 rtl/sqrt_nr_step.sv | 29 ++
 rtl/rms_sqrt_scheduler.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/rms_sqrt_pkg.sv
// rtl/rms_sqrt_pkg.sv - shared types, default sizes and round-robin search for the RMS sqrt scheduler
// Contents:
//   NCH_DEF, IN_W_DEF : default channel count / radicand width
//   OUT_W, CH_W       : result width and channel index width for the defaults
//   state_t           : scheduler FSM states
//   rr_pick()         : first set request at or after a pointer, wrapping at nch
package rms_sqrt_pkg;

  localparam int NCH_DEF  = 6;
  localparam int IN_W_DEF = 48;
  localparam int OUT_W    = IN_W_DEF / 2;
  localparam int CH_W     = $clog2(NCH_DEF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Scanning offsets from high to low leaves the smallest offset from ptr as
  // the winner. Returns ptr when nothing is requested; callers gate on |req.
  function automatic int rr_pick(input logic [15:0] req, input int ptr, input int nch);
    int idx;
    rr_pick = ptr;
    for (int k = nch - 1; k >= 0; k--) begin
      idx = ptr + k;
      if (idx >= nch) idx = idx - nch;
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/sqrt_nr_step.sv
// rtl/sqrt_nr_step.sv - one combinational non-restoring integer square-root step
// Ports:
//   rem      in  OUT_W+2  signed partial remainder (two's complement)
//   q        in  OUT_W    partial root so far
//   top2     in  2        next two radicand bits, MSB first
//   rem_next out OUT_W+2  updated remainder
//   q_bit    out 1        new root bit (1 when rem_next is non-negative)
module sqrt_nr_step #(
  parameter int OUT_W = rms_sqrt_pkg::OUT_W
) (
  input  logic [OUT_W+1:0] rem,
  input  logic [OUT_W-1:0] q,
  input  logic [1:0]       top2,
  output logic [OUT_W+1:0] rem_next,
  output logic             q_bit
);

  logic [OUT_W+1:0] shifted;

  // Arithmetic is modulo 2^(OUT_W+2); the true remainder always fits in that
  // signed range, so bits shifted out of the top carry no information.
  always_comb begin
    shifted = (rem << 2) | {{OUT_W{1'b0}}, top2};
    if (rem[OUT_W+1]) rem_next = shifted + {q, 2'b11};
    else              rem_next = shifted - {q, 2'b01};
    q_bit = ~rem_next[OUT_W+1];
  end

endmodule

// File: rtl/rms_sqrt_scheduler.sv
// rtl/rms_sqrt_scheduler.sv - round-robin sharing of one iterative sqrt engine between NCH requesters
// Optional feature macro: SQRT_ROUND_EN (round-to-nearest result, saturating).
// Ports:
//   clk, rst   in   clock; synchronous active-high reset
//   req        in   NCH        per-channel request
//   num_in     in   NCH*IN_W   radicand of channel c at [c*IN_W +: IN_W]
//   ack        out  NCH        one-cycle pulse when channel operand is captured
//   busy       out  1          operation in flight (grant through DONE)
//   res_valid  out  1          one-cycle result pulse
//   res_data   out  OUT_W      square root result, held until next result
//   res_ch     out  CH_W       channel of res_data, held until next result
module rms_sqrt_scheduler #(
  parameter int NCH  = rms_sqrt_pkg::NCH_DEF,
  parameter int IN_W = rms_sqrt_pkg::IN_W_DEF,
  parameter int OUT_W = IN_W / 2,
  parameter int CH_W = $clog2(NCH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        req,
  input  logic [NCH*IN_W-1:0]   num_in,
  output logic [NCH-1:0]        ack,
  output logic                  busy,
  output logic                  res_valid,
  output logic [OUT_W-1:0]      res_data,
  output logic [CH_W-1:0]       res_ch
);

  import rms_sqrt_pkg::*;

  localparam int CNT_W = $clog2(OUT_W + 1);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IN_W-1:0]   rad_q, rad_d;
  logic [OUT_W+1:0]  rem_q, rem_d;
  logic [OUT_W-1:0]  root_q, root_d;
  logic [NCH-1:0]    ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              res_valid_q, res_valid_d;
  logic [OUT_W-1:0]  res_data_q, res_data_d;
  logic [CH_W-1:0]   res_ch_q, res_ch_d;

  logic [15:0]       req_ext;
  logic [CH_W-1:0]   grant;
  logic              last_iter;
  logic [OUT_W+1:0]  step_rem;
  logic              step_bit;
  logic [OUT_W-1:0]  root_full;
  logic [OUT_W-1:0]  final_root;

  sqrt_nr_step #(.OUT_W(OUT_W)) u_step (
    .rem      (rem_q),
    .q        (root_q),
    .top2     (rad_q[IN_W-1 -: 2]),
    .rem_next (step_rem),
    .q_bit    (step_bit)
  );

  assign root_full = {root_q[OUT_W-2:0], step_bit};
  assign last_iter = (cnt_q == CNT_W'(OUT_W - 1));

`ifdef SQRT_ROUND_EN
  logic [OUT_W+1:0] rem_fix;

  // Final correction restores a non-negative remainder (N - q^2); rounding up
  // when it exceeds q means sqrt(N) > q + 0.5. All-ones root saturates.
  always_comb begin
    rem_fix = step_rem[OUT_W+1] ? step_rem + {1'b0, root_full, 1'b1} : step_rem;
    if ((rem_fix > {2'b00, root_full}) && (root_full != {OUT_W{1'b1}}))
      final_root = root_full + 1'b1;
    else
      final_root = root_full;
  end
`else
  assign final_root = root_full;
`endif

  always_comb begin
    req_ext = '0;
    req_ext[NCH-1:0] = req;
    grant = CH_W'(rr_pick(req_ext, int'(ptr_q), NCH));
  end

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      ch_q        <= '0;
      cnt_q       <= '0;
      rad_q       <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      rad_q       <= rad_d;
      rem_q       <= rem_d;
      root_q      <= root_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ch_q    <= res_ch_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|req) state_d = S_ITER;
      S_ITER:  if (last_iter) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath logic
  always_comb begin
    ptr_d       = ptr_q;
    ch_d        = ch_q;
    cnt_d       = cnt_q;
    rad_d       = rad_q;
    rem_d       = rem_q;
    root_d      = root_q;
    ack_d       = '0;
    busy_d      = busy_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_ch_d    = res_ch_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          ch_d       = grant;
          rad_d      = num_in[int'(grant)*IN_W +: IN_W];
          rem_d      = '0;
          root_d     = '0;
          cnt_d      = '0;
          ptr_d      = (grant == CH_W'(NCH - 1)) ? '0 : grant + 1'b1;
          ack_d[grant] = 1'b1;
          busy_d     = 1'b1;
        end
      end
      S_ITER: begin
        rem_d  = step_rem;
        root_d = root_full;
        rad_d  = rad_q << 2;
        cnt_d  = cnt_q + 1'b1;
        if (last_iter) begin
          res_valid_d = 1'b1;
          res_data_d  = final_root;
          res_ch_d    = ch_q;
        end
      end
      S_DONE: begin
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign ack       = ack_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_ch    = res_ch_q;

endmodule
